// File: rtl/key_event_detector.sv
// Key event detector: turns a debounced key level into press/release/long-press/repeat/double-click events.
// Define KEY_DOUBLE_CLICK_EN to compile in double-click detection (adds the WINDOW state).
module key_event_detector #(
    parameter int unsigned LONG_TICKS   = 50000000,
    parameter int unsigned REPEAT_TICKS = 10000000,
    parameter int unsigned DOUBLE_TICKS = 15000000
) (
    input  logic clock,
    input  logic reset_n,
    input  logic in_i,
    output logic press_o,
    output logic release_o,
    output logic long_press_o,
    output logic repeat_o,
    output logic double_click_o,
    output logic held_o
);

    localparam int unsigned MAX_LR    = (LONG_TICKS > REPEAT_TICKS) ? LONG_TICKS : REPEAT_TICKS;
    localparam int unsigned MAX_TICKS = (MAX_LR > DOUBLE_TICKS) ? MAX_LR : DOUBLE_TICKS;
    localparam int unsigned CNT_W     = $clog2(MAX_TICKS + 1);

    localparam logic [CNT_W-1:0] LONG_LAST   = CNT_W'(LONG_TICKS - 1);
    localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_TICKS - 1);

`ifdef KEY_DOUBLE_CLICK_EN
    localparam logic [CNT_W-1:0] DOUBLE_LAST = CNT_W'(DOUBLE_TICKS - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HOLD   = 2'd1,
        LONG   = 2'd2,
        WINDOW = 2'd3
    } state_e;
`else
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        LONG = 2'd2
    } state_e;
`endif

    state_e           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             in_q;
    logic             rise;
    logic             fall;

    assign rise = in_i & ~in_q;
    assign fall = ~in_i & in_q;

`ifdef KEY_DOUBLE_CLICK_EN
    // Set when the current hold began as a double click, so its release does not arm another window.
    logic dbl_q;
`else
    assign double_click_o = 1'b0;
`endif

    // Event FSM; the single counter times the hold, the repeat period and the double-click window.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            in_q         <= 1'b0;
            press_o      <= 1'b0;
            release_o    <= 1'b0;
            long_press_o <= 1'b0;
            repeat_o     <= 1'b0;
            held_o       <= 1'b0;
`ifdef KEY_DOUBLE_CLICK_EN
            double_click_o <= 1'b0;
            dbl_q          <= 1'b0;
`endif
        end else begin
            in_q         <= in_i;
            press_o      <= 1'b0;
            release_o    <= 1'b0;
            long_press_o <= 1'b0;
            repeat_o     <= 1'b0;
`ifdef KEY_DOUBLE_CLICK_EN
            double_click_o <= 1'b0;
`endif
            case (state_q)
                IDLE: begin
                    if (rise) begin
                        press_o <= 1'b1;
                        held_o  <= 1'b1;
                        cnt_q   <= '0;
                        state_q <= HOLD;
`ifdef KEY_DOUBLE_CLICK_EN
                        dbl_q   <= 1'b0;
`endif
                    end
                end
                HOLD: begin
                    if (fall) begin
                        release_o <= 1'b1;
                        held_o    <= 1'b0;
                        cnt_q     <= '0;
`ifdef KEY_DOUBLE_CLICK_EN
                        state_q   <= dbl_q ? IDLE : WINDOW;
`else
                        state_q   <= IDLE;
`endif
                    end else if (cnt_q == LONG_LAST) begin
                        long_press_o <= 1'b1;
                        cnt_q        <= '0;
                        state_q      <= LONG;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                LONG: begin
                    if (fall) begin
                        release_o <= 1'b1;
                        held_o    <= 1'b0;
                        cnt_q     <= '0;
                        state_q   <= IDLE;
                    end else if (cnt_q == REPEAT_LAST) begin
                        repeat_o <= 1'b1;
                        cnt_q    <= '0;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
`ifdef KEY_DOUBLE_CLICK_EN
                WINDOW: begin
                    // A rise on the last window cycle still counts as a double click.
                    if (rise) begin
                        press_o        <= 1'b1;
                        double_click_o <= 1'b1;
                        held_o         <= 1'b1;
                        dbl_q          <= 1'b1;
                        cnt_q          <= '0;
                        state_q        <= HOLD;
                    end else if (cnt_q == DOUBLE_LAST) begin
                        cnt_q   <= '0;
                        state_q <= IDLE;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
`endif
                default: begin
                    cnt_q   <= '0;
                    held_o  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/key_event_detector.md
KEY_EVENT_DETECTOR -- requirements
Module: key_event_detector

Interface
REQ-001 The block SHALL have parameter LONG_TICKS, default 50000000: hold cycles from press pulse to long_press pulse (minimum 2).
REQ-002 The block SHALL have parameter REPEAT_TICKS, default 10000000: cycles between successive repeat pulses (minimum 2).
REQ-003 The block SHALL have parameter DOUBLE_TICKS, default 15000000: double-click window in cycles after a release (minimum 2).
REQ-004 The block SHALL have port clock  input  1  system clock; all logic is on its rising edge.
REQ-005 The block SHALL have port reset_n  input  1  reset, asynchronous, active-low.
REQ-006 The block SHALL have port in  input  1  debounced, synchronous key level; 1 = pressed.
REQ-007 The block SHALL have port press  output  1  one-cycle pulse on key press.
REQ-008 The block SHALL have port release  output  1  one-cycle pulse on key release.
REQ-009 The block SHALL have port long_press  output  1  one-cycle pulse when hold reaches LONG_TICKS.
REQ-010 The block SHALL have port repeat  output  1  one-cycle auto-repeat pulse while held after long_press.
REQ-011 The block SHALL have port double_click  output  1  one-cycle pulse on second short press within the window.
REQ-012 The block SHALL have port held  output  1  level; 1 from the press pulse cycle until the release pulse cycle, exclusive of the release cycle.

Function
REQ-013 All outputs SHALL be registered; in SHALL be sampled into in_q each cycle; rise = in & ~in_q; fall = ~in & in_q.
REQ-014 press SHALL assert for exactly one cycle, one cycle after the clock edge on which rise is detected; release likewise for fall.
REQ-015 FSM states SHALL be IDLE, HOLD, LONG, and WINDOW (WINDOW only when the macro is defined).
REQ-016 IDLE -> HOLD on rise; the shared cycle counter SHALL clear to 0 on entry.
REQ-017 In HOLD, the counter SHALL increment each cycle; long_press SHALL pulse exactly LONG_TICKS cycles after the press pulse, with a transition to LONG and the counter cleared.
REQ-018 In LONG, repeat SHALL pulse every REPEAT_TICKS cycles after long_press (first repeat REPEAT_TICKS cycles after long_press) while in stays 1.
REQ-019 On fall in HOLD, the FSM SHALL go to WINDOW (macro defined) or IDLE (macro undefined); on fall in LONG, it SHALL go to IDLE; no long_press/repeat after fall.
REQ-020 A fall in the same cycle a long_press or repeat would fire SHALL suppress that pulse; release wins.
REQ-021 The counter width SHALL be $clog2(max(LONG_TICKS, REPEAT_TICKS, DOUBLE_TICKS)+1); the counter SHALL never wrap while held; in LONG it SHALL reload to 0 at each repeat.
REQ-022 At most one of press/release SHALL be high in any cycle; double_click SHALL only coincide with press.

Reset
REQ-023 On reset_n low, all outputs, in_q, the counter and the FSM (IDLE) SHALL clear immediately, regardless of state.
REQ-024 If in = 1 when reset_n deasserts, a press pulse SHALL follow one cycle later, because in_q resets to 0.

Configuration
REQ-025 Macro KEY_DOUBLE_CLICK_EN SHALL compile in double-click detection.
REQ-026 With KEY_DOUBLE_CLICK_EN defined, WINDOW SHALL count up from release; a rise within DOUBLE_TICKS cycles SHALL give press and double_click in the same cycle, then go to HOLD; on timeout, the FSM SHALL go to IDLE.
REQ-027 A press that produced double_click SHALL NOT arm a new window (a third click is a plain press).
REQ-028 Without KEY_DOUBLE_CLICK_EN, the double_click port SHALL exist, tied to 0, and WINDOW logic SHALL be absent.

Verification (LONG_TICKS=8, REPEAT_TICKS=4, DOUBLE_TICKS=6)
REQ-029 The bench SHALL cover: in 0->1 at cycle 10, held 3 cycles -> press at 11, held 11..13, release at 14, no long_press.
REQ-030 The bench SHALL cover: in held 30 cycles from cycle 10 -> press 11, long_press 19, repeat 23, 27, 31, 35, 39; release 41.
REQ-031 The bench SHALL cover (macro on): two 2-cycle presses separated by a 3-cycle gap -> second press with double_click=1; a third press 3 cycles later -> press only.
REQ-032 The bench SHALL cover (macro on): gap of 8 cycles between short presses -> no double_click; (macro off) any gap -> double_click stays 0.
REQ-033 The bench SHALL cover: reset_n pulsed low during LONG with in=1 -> all outputs 0 at once; press 1 cycle after reset_n release, long_press 8 cycles after that.
REQ-034 The bench SHALL cover: in falls on the exact cycle long_press would fire -> release only, no long_press.
